// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared definitions for the multi-cycle divider sequencer.
//   DIV_DW        default operand/result width
//   STALL_EX_IDX  bit of the pipeline stall vector owned by the EX stage;
//                 the pipeline controller ORs stallreq_for_div into it
//   div_state_e   2-bit sequencer state encoding
package div_seq_pkg;

  localparam int DIV_DW       = 32;
  localparam int STALL_EX_IDX = 2;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divider sequencer connection.
//   master (EX side): drives flush, start, signed_op, dividend, divisor;
//                     receives stallreq_for_div, ready, quotient, remainder
//   slave  (divider): the mirror image
interface div_seq_if #(
  parameter int DW = 32
);
  logic          flush;
  logic          start;
  logic          signed_op;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          stallreq_for_div;
  logic          ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;

  modport master (
    output flush, start, signed_op, dividend, divisor,
    input  stallreq_for_div, ready, quotient, remainder
  );

  modport slave (
    input  flush, start, signed_op, dividend, divisor,
    output stallreq_for_div, ready, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   work_i    {partial remainder, dividend/quotient bits}, 2*DW bits
//   divisor_i magnitude of the divisor
//   work_o    working register after shifting in one quotient bit
module div_step #(
  parameter int DW = 32
) (
  input  logic [2*DW-1:0] work_i,
  input  logic [DW-1:0]   divisor_i,
  output logic [2*DW-1:0] work_o
);
  // One extra bit on top keeps the bit shifted out of the partial
  // remainder, which can exceed DW bits before the subtraction.
  logic [2*DW:0] shifted;
  logic [DW:0]   upper;
  logic [DW-1:0] diff;

  always_comb begin
    shifted = {work_i, 1'b0};
    upper   = shifted[2*DW:DW];
    // The true difference is below the divisor, so DW bits are enough.
    diff    = upper[DW-1:0] - divisor_i;
    if (upper >= {1'b0, divisor_i}) begin
      work_o = {diff, shifted[DW-1:1], 1'b1};
    end else begin
      work_o = shifted[2*DW-1:0];
    end
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: sequencer for a radix-2 DIV/DIVU unit in the EX stage.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  div_seq_if.slave: start/flush/operands in; stall request,
//        single-cycle ready pulse and registered quotient/remainder out
// Normal divides take DW iterations (ready in cycle DW+1 after acceptance);
// divide-by-zero short-cuts through DIV_ZERO (ready in cycle 2).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic clk,
  input  logic rst,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(DW) + 1;

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [2*DW-1:0] work_q;
  logic [2*DW-1:0] work_step;
  logic [DW-1:0] divisor_q;
  logic          neg_dvd_q;
  logic          neg_dvs_q;
  logic          ready_q;
  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;

  logic [DW-1:0] dividend_abs;
  logic [DW-1:0] divisor_abs;
  logic [DW-1:0] quot_fix;
  logic [DW-1:0] rem_fix;

  // Negating the most negative value yields the same bit pattern, which read
  // unsigned is exactly its magnitude.
  assign dividend_abs = (bus.signed_op && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
  assign divisor_abs  = (bus.signed_op && bus.divisor[DW-1])  ? -bus.divisor  : bus.divisor;

  div_step #(.DW(DW)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  // Sign fix-up applied to the final iteration's output. The neg flags are
  // only ever set for signed operations, so DIVU passes straight through.
  assign quot_fix = (neg_dvd_q ^ neg_dvs_q) ? -work_step[DW-1:0]    : work_step[DW-1:0];
  assign rem_fix  = neg_dvd_q               ? -work_step[2*DW-1:DW] : work_step[2*DW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      neg_dvd_q   <= 1'b0;
      neg_dvs_q   <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (bus.flush) begin
        state_q <= DIV_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          DIV_IDLE: begin
            if (bus.start) begin
              neg_dvd_q <= bus.signed_op & bus.dividend[DW-1];
              neg_dvs_q <= bus.signed_op & bus.divisor[DW-1];
              divisor_q <= divisor_abs;
              cnt_q     <= '0;
              if (bus.divisor == '0) begin
                // Keep the raw dividend: it is the remainder for x/0.
                work_q  <= {{DW{1'b0}}, bus.dividend};
                state_q <= DIV_ZERO;
              end else begin
                work_q  <= {{DW{1'b0}}, dividend_abs};
                state_q <= DIV_ON;
              end
            end
          end
          DIV_ON: begin
            work_q <= work_step;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
              state_q     <= DIV_DONE;
              ready_q     <= 1'b1;
              quotient_q  <= quot_fix;
              remainder_q <= rem_fix;
            end
          end
          DIV_ZERO: begin
            state_q     <= DIV_DONE;
            ready_q     <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= work_q[DW-1:0];
          end
          DIV_DONE: begin
            // start during DONE belongs to the op just finishing; ignore it.
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
          end
          default: state_q <= DIV_IDLE;
        endcase
      end
    end
  end

  assign bus.stallreq_for_div = !rst && !bus.flush &&
                                (((state_q == DIV_IDLE) && bus.start) ||
                                 (state_q == DIV_ON) || (state_q == DIV_ZERO));
  assign bus.ready     = ready_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq. Expected results come from a
// behavioural model (native SV division) pushed into a scoreboard queue when
// an operation is started and popped when ready is observed.
module tb_div_seq;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  exp_t last_res = '0;

  div_seq_if #(.DW(DW)) dut_if ();

  div_seq #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int sa;
    int sb;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = '0;
    end else if (s) begin
      sa  = a;
      sb  = b;
      e.q = $unsigned(sa / sb);
      e.r = $unsigned(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drives one operation from a negedge (cycle 0), holds start until ready,
  // and reports what was observed. Cycle numbers are relative to acceptance.
  task automatic do_div(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int rdy_cyc, output int stall_cnt, output int stall_last,
                        output logic [DW-1:0] q, output logic [DW-1:0] r, output int rdy_abs);
    @(negedge clk);
    dut_if.start     = 1'b1;
    dut_if.signed_op = s;
    dut_if.dividend  = a;
    dut_if.divisor   = b;
    sb_q.push_back(model(s, a, b));
    rdy_cyc = -1; stall_cnt = 0; stall_last = -1; q = '0; r = '0; rdy_abs = 0;
    for (int c = 0; c <= DW + 8; c++) begin
      #1;
      if (dut_if.stallreq_for_div) begin
        stall_cnt++;
        stall_last = c;
      end
      if (dut_if.ready) begin
        rdy_cyc = c;
        q = dut_if.quotient;
        r = dut_if.remainder;
        rdy_abs = cyc;
        break;
      end
      @(negedge clk);
    end
    dut_if.start = 1'b0;
    $display("[TB] %s %08h / %08h -> q=%08h r=%08h ready@%0d stall_cycles=%0d",
             s ? "DIV " : "DIVU", a, b, q, r, rdy_cyc, stall_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dut_if.flush = 1'b0; dut_if.start = 1'b1; dut_if.signed_op = 1'b0;
    dut_if.dividend = 32'd100; dut_if.divisor = 32'd7;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (dut_if.stallreq_for_div !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b want 0", dut_if.stallreq_for_div);
    end
    dut_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (dut_if.ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 0", dut_if.ready);
    end
    tests_run++;
    if (dut_if.quotient !== '0 || dut_if.remainder !== '0) begin
      tests_failed++; $display("FAIL reset_result: got q=%h r=%h want 0/0", dut_if.quotient, dut_if.remainder);
    end
    tests_run++;
    if (dut_if.stallreq_for_div !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle_stall: got %b want 0", dut_if.stallreq_for_div);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_divu();
    int rc, sc, sl, ra; logic [DW-1:0] q, r; exp_t e;
    do_div(1'b0, 32'd100, 32'd7, rc, sc, sl, q, r, ra);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e;
    tests_run++;
    if (rc !== DW + 1) begin tests_failed++; $display("FAIL divu_latency: got %0d want %0d", rc, DW + 1); end
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++; $display("FAIL divu_result: got %h r %h want %h r %h", q, r, e.q, e.r);
    end
    tests_run++;
    if (sl !== DW || sc !== DW + 1) begin
      tests_failed++; $display("FAIL divu_stall: got last=%0d count=%0d want %0d/%0d", sl, sc, DW, DW + 1);
    end
  endtask

  task automatic test_div_signed();
    int rc, sc, sl, ra; logic [DW-1:0] q, r, a, b; exp_t e; bit s;
    do_div(1'b1, -32'sd100, 32'd7, rc, sc, sl, q, r, ra);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e;
    tests_run++;
    if (q !== e.q || r !== e.r || rc !== DW + 1) begin
      tests_failed++; $display("FAIL div_neg: got %h r %h @%0d want %h r %h @%0d", q, r, rc, e.q, e.r, DW + 1);
    end
    for (int i = 0; i < 8; i++) begin
      s = 1'(i % 2);
      a = $urandom;
      b = $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) b = -b;
      do_div(s, a, b, rc, sc, sl, q, r, ra);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      last_res = e;
      tests_run++;
      if (q !== e.q || r !== e.r || rc !== DW + 1) begin
        tests_failed++;
        $display("FAIL div_rand%0d: got %h r %h @%0d want %h r %h @%0d", i, q, r, rc, e.q, e.r, DW + 1);
      end
    end
  endtask

  task automatic test_div_zero();
    int rc, sc, sl, ra; logic [DW-1:0] q, r; exp_t e;
    do_div(1'b1, 32'd5, 32'd0, rc, sc, sl, q, r, ra);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e;
    tests_run++;
    if (rc !== 2) begin tests_failed++; $display("FAIL divzero_latency: got %0d want 2", rc); end
    tests_run++;
    if (q !== e.q || r !== e.r) begin
      tests_failed++; $display("FAIL divzero_result: got %h r %h want %h r %h", q, r, e.q, e.r);
    end
    tests_run++;
    if (sl !== 1 || sc !== 2) begin
      tests_failed++; $display("FAIL divzero_stall: got last=%0d count=%0d want 1/2", sl, sc);
    end
  endtask

  task automatic test_overflow();
    int rc, sc, sl, ra; logic [DW-1:0] q, r; exp_t e;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rc, sc, sl, q, r, ra);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e;
    tests_run++;
    if (q !== e.q || r !== e.r || rc !== DW + 1) begin
      tests_failed++; $display("FAIL div_overflow: got %h r %h @%0d want %h r %h", q, r, rc, e.q, e.r);
    end
  endtask

  task automatic test_flush();
    int pulses, rc, sc, sl, ra; logic [DW-1:0] q, r; exp_t e;
    @(negedge clk);
    dut_if.start = 1'b1; dut_if.signed_op = 1'b0;
    dut_if.dividend = 32'd1000; dut_if.divisor = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    dut_if.flush = 1'b1;
    #1;
    tests_run++;
    if (dut_if.stallreq_for_div !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stall_now: got %b want 0", dut_if.stallreq_for_div);
    end
    @(negedge clk);
    dut_if.flush = 1'b0; dut_if.start = 1'b0;
    #1;
    tests_run++;
    if (dut_if.stallreq_for_div !== 1'b0 || dut_if.ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_idle: got stall=%b ready=%b want 0/0", dut_if.stallreq_for_div, dut_if.ready);
    end
    pulses = 0;
    for (int c = 0; c < DW + 8; c++) begin
      @(negedge clk); #1;
      if (dut_if.ready === 1'b1 || dut_if.stallreq_for_div === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL flush_no_ready: got %0d busy cycles want 0", pulses); end
    tests_run++;
    if (dut_if.quotient !== last_res.q || dut_if.remainder !== last_res.r) begin
      tests_failed++; $display("FAIL flush_hold: got %h r %h want %h r %h",
                               dut_if.quotient, dut_if.remainder, last_res.q, last_res.r);
    end
    $display("[TB] DIVU 1000/3 flushed at cycle 10");
    do_div(1'b0, 32'd9, 32'd3, rc, sc, sl, q, r, ra);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e;
    tests_run++;
    if (q !== e.q || r !== e.r || rc !== DW + 1) begin
      tests_failed++; $display("FAIL flush_restart: got %h r %h @%0d want %h r %h", q, r, rc, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    dut_if.start = 1'b1; dut_if.signed_op = 1'b0;
    dut_if.dividend = 32'd100; dut_if.divisor = 32'd7;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (dut_if.ready !== 1'b0 || dut_if.quotient !== '0 || dut_if.remainder !== '0 ||
        dut_if.stallreq_for_div !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid: got ready=%b q=%h r=%h stall=%b want 0",
                               dut_if.ready, dut_if.quotient, dut_if.remainder, dut_if.stallreq_for_div);
    end
    dut_if.start = 1'b0;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < DW + 4; c++) begin
      @(negedge clk); #1;
      if (dut_if.ready === 1'b1 || dut_if.stallreq_for_div === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL reset_mid_idle: got %0d busy cycles want 0", pulses); end
    last_res = '0;
    $display("[TB] DIVU 100/7 reset at cycle 15");
  endtask

  task automatic test_back_to_back();
    int rc1, rc2, sc, sl, ra1, ra2; logic [DW-1:0] q1, r1, q2, r2; exp_t e1, e2;
    do_div(1'b0, 32'd7, 32'd2, rc1, sc, sl, q1, r1, ra1);
    do_div(1'b0, 32'd9, 32'd4, rc2, sc, sl, q2, r2, ra2);
    e1 = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    e2 = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    last_res = e2;
    tests_run++;
    if (q1 !== e1.q || r1 !== e1.r) begin
      tests_failed++; $display("FAIL b2b_first: got %h r %h want %h r %h", q1, r1, e1.q, e1.r);
    end
    tests_run++;
    if (q2 !== e2.q || r2 !== e2.r) begin
      tests_failed++; $display("FAIL b2b_second: got %h r %h want %h r %h", q2, r2, e2.q, e2.r);
    end
    tests_run++;
    if (rc1 < 0 || rc2 < 0 || (ra2 - ra1) !== DW + 2) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d cycles want %0d", ra2 - ra1, DW + 2);
    end
    tests_run++;
    if (sb_q.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_empty: got %0d left want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_seq.md
# div_seq

Sequencer for a multi-cycle radix-2 integer divider in the EX stage. It accepts a DIV/DIVU operation from EX and iterates one quotient bit per cycle. While the divide is in flight it raises an EX stall request toward the pipeline controller, which ORs it into `stallreq_from_ex`. It then presents quotient/remainder for exactly one cycle so EX can forward them to the HI/LO write path.

## Interface
Parameters:
- `DW`, 32, operand/result width; the iteration counter is `$clog2(DW)+1` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort any in-flight divide (exception/branch flush).
- `start`  in  1  DIV/DIVU is in EX; held high by EX while stalled.
- `signed_op`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `dividend`  in  DW  numerator, sampled in IDLE when `start` is accepted.
- `divisor`  in  DW  denominator, sampled together with `dividend`.
- `stallreq_for_div`  out  1  EX stall request.
- `ready`  out  1  result valid, single-cycle pulse.
- `quotient`  out  DW  result quotient, goes to LO.
- `remainder`  out  DW  result remainder, goes to HI.

## Operation
- States: IDLE, DIV_ZERO, DIV_ON, DONE.
- **IDLE**
  - `start & !flush` latches the operands.
  - If `signed_op` is set, the operands are latched as absolute values. Their signs are recorded.
  - If `divisor == 0`, go to DIV_ZERO. Otherwise go to DIV_ON with `cnt = 0`.
- **DIV_ON**, one iteration per cycle:
  - Shift the 2·DW-bit working register left by one.
  - Compare the upper DW+1 bits with `{1'b0, |divisor|}`.
  - If greater or equal, subtract and set bit 0.
  - `cnt` increments. After the iteration with `cnt == DW-1`, go to DONE.
- **DIV_ZERO**: one cycle, then DONE.
  - Quotient is all ones.
  - Remainder is the original (un-normalised) dividend.
- **DONE**: `ready = 1` for one cycle, then unconditionally IDLE.
  - Signed sign fix-up: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Unsigned: no fix-up.
- `quotient`/`remainder` are registered. They hold their last value after DONE and are overwritten only at the next DONE.
- `stallreq_for_div` is combinational:
  - 1 when IDLE and `start & !flush`.
  - 1 in DIV_ON or DIV_ZERO when `!flush`.
  - 0 in DONE and whenever `flush` is high.
- **Flush**: `flush` in any state forces IDLE on the next edge. `ready` is not asserted for the aborted op, and the result registers are not updated.
- **Arithmetic edge cases**:
  - Signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000` (wrap) and remainder 0.
  - |`0x80000000`| is taken as unsigned `0x80000000`.
- **Back-to-back divides**: a new `start` in the cycle after DONE is a fresh operation from IDLE. `start` seen during DONE is ignored.

## Timing
- **Reset**: state IDLE, `cnt` 0, `ready` 0, `quotient` 0, `remainder` 0. `stallreq_for_div` is 0 during reset regardless of `start`.
- **Normal divide** (start accepted in cycle 0):
  - DIV_ON in cycles 1..DW.
  - DONE/`ready` in cycle DW+1, i.e. 33 for DW=32.
  - Stall is high in cycles 0..DW; the pipeline advances at the end of cycle DW+1.
- **Divide by zero**: DIV_ZERO in cycle 1, DONE in cycle 2; stall is high in cycles 0–1.
- **`rst` and `flush` together**: `rst` wins; the result is identical either way.

## Structure
- Shared defines/package:
  - State encodings `DIV_IDLE`, `DIV_ZERO`, `DIV_ON`, `DIV_DONE` (2-bit).
  - `DW`.
  - The stall-vector bit index for EX, so the pipeline controller and this block agree.
- One natural sub-module: `div_step`, a combinational single iteration. It takes the working register and divisor and returns the next working register.
- The FSM, counter, sign handling and result registers stay in `div_seq`.

## Test plan
- DIVU `100 / 7`: `ready` at cycle 33, quotient 14, remainder 2. Stall is high for cycles 0–32 and low at 33.
- DIV `-100 / 7`: quotient `0xFFFFFFF2` (−14), remainder `0xFFFFFFFE` (−2).
- DIV `5 / 0`: `ready` at cycle 2, quotient `0xFFFFFFFF`, remainder 5. Stall is high for cycles 0–1 only.
- DIV `0x80000000 / 0xFFFFFFFF`: quotient `0x80000000`, remainder 0.
- Flush:
  - Start DIVU `1000 / 3`, then assert `flush` at cycle 10.
  - Next cycle the FSM is IDLE, stall is 0, and `ready` never pulses. Result registers keep their previous values.
  - Restarting DIVU `9 / 3` gives 3 r 0.
- Reset:
  - Assert `rst` mid-divide (cycle 15). Outputs are 0 and the FSM is IDLE.
  - Back-to-back DIVU `7/2` then `9/4` (start re-asserted the cycle after DONE) gives 3 r 1 and then 2 r 1, with `ready` pulses 34 cycles apart.
